// File: rtl/instruction_buffer.sv
// Fetch-to-decode instruction FIFO with first-word fall-through output
// and a single-cycle flush for discarding wrong-path instructions.
//
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   inst_in, pc_in   instruction and its PC from fetch
//   inst_valid_in    fetch presents an instruction
//   inst_ready_out   buffer not full; a push is accepted this cycle
//   flush_in         branch taken; empties the buffer, overrides push/pop
//   inst_out, pc_out head entry (zero when empty)
//   inst_valid_out   head entry is valid
//   inst_ready_in    decode consumes the head this cycle
//   count_out        occupied entries, 0..DEPTH
module instruction_buffer #(
    parameter int unsigned INST_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PTR_W  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INST_W-1:0]   inst_in,
    input  logic [PC_W-1:0]     pc_in,
    input  logic                inst_valid_in,
    output logic                inst_ready_out,
    input  logic                flush_in,
    output logic [INST_W-1:0]   inst_out,
    output logic [PC_W-1:0]     pc_out,
    output logic                inst_valid_out,
    input  logic                inst_ready_in,
    output logic [PTR_W:0]      count_out
);

    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = INST_W + PC_W;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];

    logic               empty_c;
    logic               full_c;
    logic               push_c;
    logic               pop_c;
    logic [ENTRY_W-1:0] head_c;

    // Occupancy flags are pure functions of the registered count.
    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == CNT_W'(DEPTH));

    // Flush suppresses both handshakes so nothing is written or handed off.
    assign push_c = inst_valid_in && !full_c  && !flush_in;
    assign pop_c  = inst_ready_in && !empty_c && !flush_in;

    // Next-state for pointers, count and storage.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
        end

        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                mem_d[wr_ptr_q] = {inst_in, pc_in};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            // Push and pop together leave the count unchanged.
            if (push_c && !pop_c) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    // First-word fall-through head, forced to zero when empty.
    assign head_c         = empty_c ? '0 : mem_q[rd_ptr_q];
    assign inst_out       = head_c[ENTRY_W-1:PC_W];
    assign pc_out         = head_c[PC_W-1:0];
    assign inst_valid_out = !empty_c;
    assign inst_ready_out = !full_c;
    assign count_out      = count_q;

endmodule

// File: tb/tb_instruction_buffer.sv
// Randomized and directed checks of instruction_buffer against a queue model.
module tb_instruction_buffer;

    localparam int unsigned INST_W = 32;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PTR_W  = 2;

    logic              clk;
    logic              rst_n;
    logic [INST_W-1:0] inst_in;
    logic [PC_W-1:0]   pc_in;
    logic              inst_valid_in;
    logic              inst_ready_out;
    logic              flush_in;
    logic [INST_W-1:0] inst_out;
    logic [PC_W-1:0]   pc_out;
    logic              inst_valid_out;
    logic              inst_ready_in;
    logic [PTR_W:0]    count_out;

    int unsigned vectors;
    int unsigned miscompares;

    // Reference model: queue of {inst, pc}, head at index 0.
    logic [63:0] model_q[$];

    instruction_buffer #(
        .INST_W(INST_W), .PC_W(PC_W), .DEPTH(DEPTH), .PTR_W(PTR_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .inst_in(inst_in),
        .pc_in(pc_in),
        .inst_valid_in(inst_valid_in),
        .inst_ready_out(inst_ready_out),
        .flush_in(flush_in),
        .inst_out(inst_out),
        .pc_out(pc_out),
        .inst_valid_out(inst_valid_out),
        .inst_ready_in(inst_ready_in),
        .count_out(count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every output against the model's view of the buffer.
    task automatic check_model(input string tag);
        logic [63:0] head;
        int          n;
        n    = model_q.size();
        head = (n != 0) ? model_q[0] : 64'h0;
        check({tag, ".count"}, 64'(count_out), 64'(n));
        check({tag, ".valid"}, 64'(inst_valid_out), 64'(n != 0));
        check({tag, ".ready"}, 64'(inst_ready_out), 64'(n != int'(DEPTH)));
        check({tag, ".inst"},  64'(inst_out), 64'(head[63:32]));
        check({tag, ".pc"},    64'(pc_out),   64'(head[31:0]));
    endtask

    // One clock: drive inputs at negedge, check, then apply the model at posedge.
    task automatic step(input logic v, input logic [31:0] i, input logic [31:0] p,
                        input logic rdy, input logic fl);
        bit do_push;
        bit do_pop;
        @(negedge clk);
        inst_valid_in = v;
        inst_in       = i;
        pc_in         = p;
        inst_ready_in = rdy;
        flush_in      = fl;
        check_model("pre");
        do_push = v && (model_q.size() < int'(DEPTH)) && !fl;
        do_pop  = rdy && (model_q.size() != 0) && !fl;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back({i, p});
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        inst_in       = '0;
        pc_in         = '0;
        inst_valid_in = 1'b0;
        inst_ready_in = 1'b0;
        flush_in      = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst.count", 64'(count_out), 64'd0);
        check("rst.valid", 64'(inst_valid_out), 64'd0);
        check("rst.ready", 64'(inst_ready_out), 64'd1);
        check("rst.inst",  64'(inst_out), 64'd0);
        check("rst.pc",    64'(pc_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full, then a fifth push is refused.
        step(1'b1, 32'h11111111, 32'h00, 1'b0, 1'b0);
        step(1'b1, 32'h22222222, 32'h04, 1'b0, 1'b0);
        step(1'b1, 32'h33333333, 32'h08, 1'b0, 1'b0);
        step(1'b1, 32'h44444444, 32'h0C, 1'b0, 1'b0);
        check("full.count", 64'(count_out), 64'd4);
        check("full.ready", 64'(inst_ready_out), 64'd0);
        step(1'b1, 32'h55555555, 32'h10, 1'b0, 1'b0);
        check("full5.count", 64'(count_out), 64'd4);
        check("full5.head",  64'(inst_out), 64'h11111111);

        // Drain in order.
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("drain.inst1", 64'(inst_out), 64'h22222222);
        check("drain.pc1",   64'(pc_out), 64'h04);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("drain.inst3", 64'(inst_out), 64'h44444444);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("drain.valid", 64'(inst_valid_out), 64'd0);
        check("drain.inst",  64'(inst_out), 64'd0);
        // Pop on empty does nothing.
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("empty.count", 64'(count_out), 64'd0);

        // Wrap-around with concurrent push/pop at count 2.
        step(1'b1, 32'h1000, 32'h100, 1'b0, 1'b0);
        step(1'b1, 32'h1001, 32'h104, 1'b0, 1'b0);
        for (int k = 2; k < 12; k++) begin
            step(1'b1, 32'h1000 + 32'(k), 32'h100 + 32'(4 * k), 1'b1, 1'b0);
            check("wrap.count", 64'(count_out), 64'd2);
            check("wrap.head",  64'(inst_out), 64'(32'h1000 + 32'(k - 1)));
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush beats a simultaneous push and pop.
        step(1'b1, 32'h01, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h02, 32'h4, 1'b0, 1'b0);
        step(1'b1, 32'h03, 32'h8, 1'b0, 1'b0);
        step(1'b1, 32'hAAAAAAAA, 32'h20, 1'b1, 1'b1);
        check("flush.count", 64'(count_out), 64'd0);
        check("flush.valid", 64'(inst_valid_out), 64'd0);
        check("flush.ready", 64'(inst_ready_out), 64'd1);
        step(1'b1, 32'hBBBBBBBB, 32'h40, 1'b0, 1'b0);
        check("flush.head",  64'(inst_out), 64'hBBBBBBBB);
        check("flush.pc",    64'(pc_out), 64'h40);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Push with ready high on an empty buffer: no same-cycle pop.
        step(1'b1, 32'hCCCCCCCC, 32'h80, 1'b1, 1'b0);
        check("lat.valid", 64'(inst_valid_out), 64'd1);
        check("lat.inst",  64'(inst_out), 64'hCCCCCCCC);
        check("lat.count", 64'(count_out), 64'd1);
        step(1'b1, 32'hDD, 32'h84, 1'b0, 1'b0);
        step(1'b1, 32'hEE, 32'h88, 1'b0, 1'b0);

        // Asynchronous reset mid-stream with three entries held.
        @(negedge clk);
        inst_valid_in = 1'b0;
        inst_ready_in = 1'b0;
        check_model("prerst");
        #2;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        check("arst.count", 64'(count_out), 64'd0);
        check("arst.valid", 64'(inst_valid_out), 64'd0);
        check("arst.ready", 64'(inst_ready_out), 64'd1);
        check("arst.inst",  64'(inst_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) < 60, $urandom, $urandom,
                 $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 5);
        end
        check_model("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_buffer.md
Name: instruction_buffer

Overview:
- Small FIFO between the fetch stage and the decode stage.
- Captures each fetched 32-bit instruction together with its PC and presents the oldest entry to decode under a valid/ready handshake.
- Decouples fetch from decode stalls.
- Discards all buffered, wrong-path instructions in one cycle when a branch is taken.

Parameters:
- INST_W, 32, instruction width in bits.
- PC_W, 32, program-counter width in bits.
- DEPTH, 4, number of entries; must be a power of two, at least 2.
- PTR_W, 2, log2(DEPTH); read/write pointer width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- inst_in  input  INST_W  instruction from fetch.
- pc_in  input  PC_W  address of inst_in.
- inst_valid_in  input  1  fetch presents a valid instruction.
- inst_ready_out  output  1  buffer can accept a write this cycle.
- flush_in  input  1  branch taken; discard contents.
- inst_out  output  INST_W  oldest buffered instruction to decode.
- pc_out  output  PC_W  PC of inst_out.
- inst_valid_out  output  1  inst_out/pc_out hold a valid entry.
- inst_ready_in  input  1  decode consumes the head entry this cycle.
- count_out  output  PTR_W+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0. Outputs: inst_valid_out=0, inst_ready_out=1, count_out=0, inst_out=0, pc_out=0. Storage array contents need not be reset.
- Write (push): occurs on a clk edge when inst_valid_in && inst_ready_out && !flush_in. {inst_in, pc_in} goes to mem[wr_ptr], and wr_ptr increments modulo DEPTH (natural wrap of PTR_W bits).
- Read (pop): occurs on a clk edge when inst_valid_out && inst_ready_in && !flush_in. rd_ptr increments modulo DEPTH.
- Output timing: first-word fall-through.
  - inst_out/pc_out = mem[rd_ptr] whenever count != 0; forced to 0 when count == 0.
  - inst_valid_out = (count != 0).
- inst_ready_out = (count != DEPTH). It is purely state-based; a simultaneous pop does not allow a push when full.
- Latency: an instruction written at edge N is visible on inst_out with inst_valid_out=1 after edge N. There is no same-cycle bypass. When empty, a push and a pop cannot happen in the same cycle.
- Count update per edge:
  - push only: +1.
  - pop only: -1.
  - both (allowed only when 0 < count < DEPTH): unchanged, both pointers advance.
  - neither: unchanged.
- Flush: flush_in high at an edge sets wr_ptr=0, rd_ptr=0, count=0.
  - Flush overrides any push or pop in the same cycle. The incoming instruction is dropped and the head is not handed to decode.
  - The next cycle shows inst_valid_out=0, inst_ready_out=1.
- Full: no write is accepted. inst_in is ignored even if inst_valid_in=1, and fetch must hold it.
- Empty: inst_ready_in is ignored and no state changes.
- Invariants:
  - count never exceeds DEPTH or underflows.
  - Pointer wrap is seamless; entry order is strictly FIFO across the wrap.
- Reset asserted mid-operation: immediate return to the reset state, independent of clk. Outputs go to reset values combinationally.
- Back-pressure contract: inst_out/pc_out stay stable while inst_valid_out=1 and inst_ready_in=0, unless flush_in is asserted.

Test Plan:
- Reset/idle: assert rst_n=0 mid-stream with count=3 -> count_out=0, inst_valid_out=0, inst_ready_out=1, inst_out=0 immediately, before any clk edge.
- Fill to full: push 0x11111111@PC 0x00, 0x22222222@0x04, 0x33333333@0x08, 0x44444444@0x0C with inst_ready_in=0 -> count_out=4, inst_ready_out=0. A fifth push of 0x55555555 is ignored and count stays 4.
- Drain in order: from the full state, inst_ready_in=1 for 4 cycles -> inst_out sequence 0x11111111, 0x22222222, 0x33333333, 0x44444444 with PCs 0x00..0x0C. Then inst_valid_out=0 and inst_out=0.
- Wrap-around with concurrent push/pop:
  - Stimulus: steady 1 push + 1 pop per cycle at count=2 over 10 cycles with incrementing instructions.
  - Required response: count_out stays 2, pointers wrap past 3->0, and outputs emerge in exact write order with no loss or duplication.
- Flush precedence: count=3 and flush_in=1 in the same cycle as push 0xAAAAAAAA and pop -> next cycle count_out=0, inst_valid_out=0. A subsequent push of 0xBBBBBBBB@0x40 appears as the head one cycle later; 0xAAAAAAAA never appears.
- Empty-cycle write latency: with count=0, push 0xCCCCCCCC with inst_ready_in=1 in the same cycle -> no pop that cycle. The next cycle shows inst_valid_out=1, inst_out=0xCCCCCCCC, count_out=1.
